fb_scale_addr: RTL and testbench

Upstream address generator for the display path: converts XGA raster coordinates into frame-buffer read addresses for a 320x240 8-bit camera buffer upscaled to the 1024x768 active window. Scaling uses an incremental 5/16 DDA in both axes instead of a multiplier. Drives the frame-buffer BRAM read port and forwards coordinates delayed to match BRAM output. The window-gating stage downstream then consumes the aligned pixel and coordinates.

---
 rtl/fb_scale_addr.sv | 182 ++++++++++++++++++
 tb/tb_fb_scale_addr.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scale_addr.sv
// XGA raster to 320x240 frame-buffer address generator (5/16 DDA, no multiplier).
// Define MIRROR_EN for a horizontally mirrored read-out.
module fb_scale_addr #(
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [16:0] addr_out,
  output logic        active_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        seq_err_out
);

  localparam int DLY = 2 + BRAM_LATENCY;

  logic [8:0]  r_x_int;
  logic [3:0]  r_x_frac;
  logic [7:0]  r_y_int;
  logic [3:0]  r_y_frac;
  logic [16:0] r_line_base;
  logic [10:0] r_prev_h;
  logic        r_armed;

  logic        r_s1_act;
  logic [8:0]  r_s1_x;
  logic [16:0] r_s1_base;

  logic [10:0] r_hd [DLY];
  logic [9:0]  r_vd [DLY];

  logic        w_active;
  logic        w_h_zero;
  logic        w_v_zero;
  logic        w_seq_bad;
  logic        w_x_step;
  logic        w_y_clr;
  logic        w_y_upd;
  logic [12:0] w_h5;
  logic [4:0]  w_x_sum;
  logic [4:0]  w_y_sum;
  logic [8:0]  w_x_int;
  logic [3:0]  w_x_frac;
  logic [7:0]  w_y_int;
  logic [3:0]  w_y_frac;
  logic [16:0] w_line_base;
  logic [8:0]  w_x_sel;
  logic [16:0] w_addr;

  assign w_active = (hcount_in < 11'd1024) &&
                    (vcount_in < 10'd768);
  assign w_h_zero = (hcount_in == 11'd0);
  assign w_v_zero = (vcount_in == 10'd0);

  // The very first cycle after reset has no valid predecessor.
  assign w_seq_bad = r_armed && w_active && !w_h_zero &&
                     (hcount_in != r_prev_h + 11'd1);
  assign w_x_step = w_active && !w_h_zero && !w_seq_bad;

  assign w_y_clr = w_h_zero && w_v_zero;
  assign w_y_upd = w_h_zero && !w_v_zero &&
                   (vcount_in < 10'd768);

  assign w_h5    = {hcount_in, 2'b00} + {2'b00, hcount_in};
  assign w_x_sum = {1'b0, r_x_frac} + 5'd5;
  assign w_y_sum = {1'b0, r_y_frac} + 5'd5;

  always_comb begin
    w_x_int  = r_x_int;
    w_x_frac = r_x_frac;
    unique case (1'b1)
      w_h_zero: begin
        w_x_int  = 9'd0;
        w_x_frac = 4'd0;
      end
      w_seq_bad: begin
        w_x_int  = w_h5[12:4];
        w_x_frac = w_h5[3:0];
      end
      w_x_step: begin
        w_x_int  = r_x_int + {8'd0, w_x_sum[4]};
        w_x_frac = w_x_sum[3:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_y_int     = r_y_int;
    w_y_frac    = r_y_frac;
    w_line_base = r_line_base;
    unique case (1'b1)
      w_y_clr: begin
        w_y_int     = 8'd0;
        w_y_frac    = 4'd0;
        w_line_base = 17'd0;
      end
      w_y_upd: begin
        w_y_int     = r_y_int + {7'd0, w_y_sum[4]};
        w_y_frac    = w_y_sum[3:0];
        w_line_base = r_line_base +
                      (w_y_sum[4] ? 17'd320 : 17'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x_int     <= '0;
      r_x_frac    <= '0;
      r_y_int     <= '0;
      r_y_frac    <= '0;
      r_line_base <= '0;
      r_prev_h    <= '0;
      r_armed     <= 1'b0;
      seq_err_out <= 1'b0;
    end else begin
      r_x_int     <= w_x_int;
      r_x_frac    <= w_x_frac;
      r_y_int     <= w_y_int;
      r_y_frac    <= w_y_frac;
      r_line_base <= w_line_base;
      r_prev_h    <= hcount_in;
      r_armed     <= 1'b1;
      seq_err_out <= seq_err_out | w_seq_bad;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_act  <= 1'b0;
      r_s1_x    <= '0;
      r_s1_base <= '0;
    end else begin
      r_s1_act  <= w_active;
      r_s1_x    <= w_x_int;
      r_s1_base <= w_line_base;
    end
  end

`ifdef MIRROR_EN
  assign w_x_sel = 9'd319 - r_s1_x;
`else
  assign w_x_sel = r_s1_x;
`endif

  assign w_addr = r_s1_base + {8'd0, w_x_sel};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_out   <= '0;
      active_out <= 1'b0;
    end else begin
      addr_out   <= r_s1_act ? w_addr : 17'd0;
      active_out <= r_s1_act;
    end
  end

  // Coordinates ride alongside so they meet the BRAM read data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DLY; i++) begin
        r_hd[i] <= '0;
        r_vd[i] <= '0;
      end
    end else begin
      r_hd[0] <= hcount_in;
      r_vd[0] <= vcount_in;
      for (int i = 1; i < DLY; i++) begin
        r_hd[i] <= r_hd[i-1];
        r_vd[i] <= r_vd[i-1];
      end
    end
  end

  assign hcount_out = r_hd[DLY-1];
  assign vcount_out = r_vd[DLY-1];

endmodule

// File: tb/tb_fb_scale_addr.sv
// Directed bench for fb_scale_addr at BRAM latencies 2, 1 and 4.
// Expected addresses come from floor(5*h/16), floor(5*v/16).
module tb_fb_scale_addr;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;

  logic [16:0] addr_out, addr1, addr4;
  logic        active_out, act1, act4;
  logic [10:0] hcount_out, hout1, hout4;
  logic [9:0]  vcount_out, vout1, vout4;
  logic        seq_err_out, serr1, serr4;

  always #5 clk = ~clk;

  fb_scale_addr #(.BRAM_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .addr_out(addr_out), .active_out(active_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .seq_err_out(seq_err_out));

  fb_scale_addr #(.BRAM_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .addr_out(addr1), .active_out(act1),
    .hcount_out(hout1), .vcount_out(vout1),
    .seq_err_out(serr1));

  fb_scale_addr #(.BRAM_LATENCY(4)) dut4 (
    .clk_in(clk), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .addr_out(addr4), .active_out(act4),
    .hcount_out(hout4), .vcount_out(vout4),
    .seq_err_out(serr4));

`ifdef MIRROR_EN
  localparam logic [16:0] A00   = 17'd319;
  localparam logic [16:0] A1023 = 17'd0;
  localparam logic [16:0] A1616 = 17'd1914;
  localparam logic [16:0] ALAST = 17'd76480;
  localparam logic [16:0] A201  = 17'd257;
`else
  localparam logic [16:0] A00   = 17'd0;
  localparam logic [16:0] A1023 = 17'd319;
  localparam logic [16:0] A1616 = 17'd1605;
  localparam logic [16:0] ALAST = 17'd76799;
  localparam logic [16:0] A201  = 17'd62;
`endif

  int total = 0;
  int bad = 0;

  logic [10:0] hh [8];
  logic [9:0]  hv [8];
  bit          hchk [8];
  bit          hval [8];
  int          wp = 8;
  logic [16:0] got [int];

  logic [16:0] s_addr, s_addr1, s_addr4;
  logic        s_act, s_serr;
  logic [10:0] s_hout, s_hout1, s_hout4;
  logic [9:0]  s_vout;
  bit          e2_ok, e3_ok, e4_ok, e6_ok;
  logic [10:0] e2_h, e3_h, e4_h, e6_h;
  logic [9:0]  e2_v, e4_v;

  function automatic bit exp_act(input logic [10:0] h,
                                 input logic [9:0] v);
    return (h < 11'd1024) && (v < 10'd768);
  endfunction

  function automatic logic [16:0] exp_addr(input logic [10:0] h,
                                           input logic [9:0] v);
    int x, y;
    if (!exp_act(h, v)) return 17'd0;
    x = (5 * int'(h)) / 16;
    y = (5 * int'(v)) / 16;
`ifdef MIRROR_EN
    x = 319 - x;
`endif
    return 17'(y * 320 + x);
  endfunction

  task automatic clr_hist();
    for (int i = 0; i < 8; i++) hval[i] = 1'b0;
  endtask

  task automatic push(input logic [10:0] h, input logic [9:0] v,
                      input bit chk, input bit val);
    hh[wp % 8] = h;
    hv[wp % 8] = v;
    hchk[wp % 8] = chk;
    hval[wp % 8] = val;
    wp++;
  endtask

  task automatic tick(input int h, input int v, input bit chk);
    int i2, i3, i4, i6;
    @(negedge clk);
    s_addr = addr_out; s_act = active_out;
    s_hout = hcount_out; s_vout = vcount_out;
    s_serr = seq_err_out;
    s_addr1 = addr1; s_addr4 = addr4;
    s_hout1 = hout1; s_hout4 = hout4;
    i2 = (wp - 2) % 8; i3 = (wp - 3) % 8;
    i4 = (wp - 4) % 8; i6 = (wp - 6) % 8;
    e2_ok = hval[i2] && hchk[i2];
    e2_h = hh[i2]; e2_v = hv[i2];
    e3_ok = hval[i3]; e3_h = hh[i3];
    e4_ok = hval[i4]; e4_h = hh[i4]; e4_v = hv[i4];
    e6_ok = hval[i6]; e6_h = hh[i6];
    if (e2_ok) got[int'(e2_v) * 2048 + int'(e2_h)] = s_addr;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    push(11'(h), 10'(v), chk, 1'b1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_in = 1'b0;
    push(hcount_in, vcount_in, 1'b0, 1'b0);
  endtask

  task automatic scan_line(input int v, input int h0,
                           input int h1, input bit chk);
    logic [16:0] ea;
    bit eact;
    for (int h = h0; h <= h1; h++) begin
      tick(h, v, chk);
      if (e2_ok) begin
        ea = exp_addr(e2_h, e2_v);
        eact = exp_act(e2_h, e2_v);
        total++;
        if (s_addr !== ea || s_act !== eact) begin
          bad++;
          $display("FAIL addr h=%0d v=%0d got %0d/%0b want %0d/%0b",
                   e2_h, e2_v, s_addr, s_act, ea, eact);
        end
        total++;
        if (s_addr1 !== ea || s_addr4 !== ea) begin
          bad++;
          $display("FAIL addr_lag h=%0d v=%0d got %0d,%0d want %0d",
                   e2_h, e2_v, s_addr1, s_addr4, ea);
        end
      end
      if (e4_ok) begin
        total++;
        if (s_hout !== e4_h || s_vout !== e4_v) begin
          bad++;
          $display("FAIL coord4 got %0d,%0d want %0d,%0d",
                   s_hout, s_vout, e4_h, e4_v);
        end
      end
      if (e3_ok) begin
        total++;
        if (s_hout1 !== e3_h) begin
          bad++;
          $display("FAIL coord3 got %0d want %0d", s_hout1, e3_h);
        end
      end
      if (e6_ok) begin
        total++;
        if (s_hout4 !== e6_h) begin
          bad++;
          $display("FAIL coord6 got %0d want %0d", s_hout4, e6_h);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    hcount_in = 11'd7;
    vcount_in = 10'd3;
    repeat (3) @(negedge clk);
    total++;
    if ({addr_out, active_out, hcount_out, vcount_out,
         seq_err_out} !== '0) begin
      bad++;
      $display("FAIL reset_main got a=%0d act=%0b h=%0d v=%0d e=%0b want 0",
               addr_out, active_out, hcount_out, vcount_out, seq_err_out);
    end
    total++;
    if ({addr1, hout1, addr4, hout4, serr1, serr4} !== '0) begin
      bad++;
      $display("FAIL reset_alt got a1=%0d h1=%0d a4=%0d h4=%0d want 0",
               addr1, hout1, addr4, hout4);
    end
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    clr_hist();
    release_rst();
  endtask

  task automatic test_raster();
    got.delete();
    scan_line(0, 0, 1343, 1);
    for (int v = 1; v <= 16; v++) scan_line(v, 0, 0, 1);
    scan_line(16, 1, 16, 1);
    for (int v = 17; v <= 767; v++) scan_line(v, 0, 0, 1);
    scan_line(767, 1, 1343, 1);
    total++;
    if (got[0] !== A00) begin
      bad++;
      $display("FAIL h0v0 got %0d want %0d", got[0], A00);
    end
    total++;
    if (got[1023] !== A1023) begin
      bad++;
      $display("FAIL h1023v0 got %0d want %0d", got[1023], A1023);
    end
    total++;
    if (got[16 * 2048 + 16] !== A1616) begin
      bad++;
      $display("FAIL h16v16 got %0d want %0d",
               got[16 * 2048 + 16], A1616);
    end
    total++;
    if (got[767 * 2048 + 1023] !== ALAST) begin
      bad++;
      $display("FAIL h1023v767 got %0d want %0d",
               got[767 * 2048 + 1023], ALAST);
    end
  endtask

  task automatic test_inactive();
    got.delete();
    scan_line(768, 0, 30, 1);
    for (int v = 769; v <= 805; v++) scan_line(v, 0, 0, 1);
    scan_line(0, 0, 10, 1);
    total++;
    if (got[768 * 2048 + 5] !== 17'd0) begin
      bad++;
      $display("FAIL inactive_addr got %0d want 0",
               got[768 * 2048 + 5]);
    end
    total++;
    if (got[5] !== exp_addr(11'd5, 10'd0)) begin
      bad++;
      $display("FAIL frame_wrap got %0d want %0d",
               got[5], exp_addr(11'd5, 10'd0));
    end
    total++;
    if (s_serr !== 1'b0) begin
      bad++;
      $display("FAIL no_seq_err got %0b want 0", s_serr);
    end
  endtask

  task automatic test_seq_err();
    got.delete();
    scan_line(0, 0, 100, 1);
    total++;
    if (s_serr !== 1'b0) begin
      bad++;
      $display("FAIL seq_pre got %0b want 0", s_serr);
    end
    scan_line(0, 200, 210, 1);
    total++;
    if (s_serr !== 1'b1) begin
      bad++;
      $display("FAIL seq_rise got %0b want 1", s_serr);
    end
    total++;
    if (got[201] !== A201) begin
      bad++;
      $display("FAIL seq_h201 got %0d want %0d", got[201], A201);
    end
    scan_line(1, 0, 5, 1);
    total++;
    if (s_serr !== 1'b1) begin
      bad++;
      $display("FAIL seq_sticky got %0b want 1", s_serr);
    end
  endtask

  task automatic test_latency();
    scan_line(2, 0, 30, 1);
    total++;
    if (s_hout1 !== 11'd27 || s_hout4 !== 11'd24) begin
      bad++;
      $display("FAIL latency got h1=%0d h4=%0d want 27,24",
               s_hout1, s_hout4);
    end
  endtask

  task automatic test_midline_reset();
    scan_line(300, 495, 500, 0);
    #3 rst_in = 1'b1;
    #1;
    total++;
    if ({addr_out, active_out, hcount_out, vcount_out,
         seq_err_out} !== '0) begin
      bad++;
      $display("FAIL midreset got a=%0d act=%0b h=%0d v=%0d e=%0b want 0",
               addr_out, active_out, hcount_out, vcount_out, seq_err_out);
    end
    total++;
    if ({hout1, hout4, serr1, serr4} !== '0) begin
      bad++;
      $display("FAIL midreset_alt got h1=%0d h4=%0d want 0",
               hout1, hout4);
    end
    repeat (2) @(negedge clk);
    clr_hist();
    release_rst();
    scan_line(300, 501, 510, 0);
    total++;
    if (s_serr !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_seq got %0b want 0", s_serr);
    end
    got.delete();
    scan_line(0, 0, 40, 1);
    scan_line(1, 0, 20, 1);
    scan_line(2, 0, 1, 1);
    total++;
    if (got[0] !== A00 || got[20] !== exp_addr(11'd20, 10'd0)) begin
      bad++;
      $display("FAIL realign got %0d,%0d want %0d,%0d",
               got[0], got[20], A00, exp_addr(11'd20, 10'd0));
    end
    total++;
    if (s_serr !== 1'b0) begin
      bad++;
      $display("FAIL realign_seq got %0b want 0", s_serr);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_inactive();
    test_seq_err();
    test_latency();
    test_midline_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
